// File: rtl/conv_feeder.sv
// Input-side feeder for the conv engine: loads one weight/bias set over the weight write
// port, then packs per-channel pixel bytes into IN_CHANNEL-wide words under FIFO back-pressure.
module conv_feeder #(
   parameter int IN_CHANNEL  = 3,
   parameter int NUM_WEIGHTS = 3040,
   parameter int IMG_W       = 32,
   parameter int IMG_H       = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    skip_weights,
   input  logic [15:0]             s_w_data,
   input  logic                    s_w_valid,
   output logic                    s_w_ready,
   input  logic [7:0]              s_px_data,
   input  logic                    s_px_valid,
   output logic                    s_px_ready,
   input  logic                    fifo_almost_full,
   output logic [8*IN_CHANNEL-1:0] i_data,
   output logic                    i_valid,
   output logic [15:0]             weight_wr_data,
   output logic [31:0]             weight_wr_addr,
   output logic                    weight_wr_en,
   output logic                    busy,
   output logic                    done
);

   localparam int NUM_PIX = IMG_W * IMG_H;
   localparam int WA_W    = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
   localparam int PX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
   localparam int LANE_W  = (IN_CHANNEL > 1) ? $clog2(IN_CHANNEL) : 1;

   localparam logic [WA_W-1:0]   WADDR_LAST = WA_W'(NUM_WEIGHTS - 1);
   localparam logic [PX_W-1:0]   PIX_LAST   = PX_W'(NUM_PIX - 1);
   localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(IN_CHANNEL - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_W,
      S_STREAM,
      S_DONE
   } state_e;

   state_e                         state_q, state_d;
   logic [WA_W-1:0]                waddr_q, waddr_d;
   logic [PX_W-1:0]                pix_q, pix_d;
   logic [LANE_W-1:0]              lane_q, lane_d;
   logic [IN_CHANNEL-1:0][7:0]     part_q, part_d;
   logic                           wr_en_q, wr_en_d;
   logic [15:0]                    wr_data_q, wr_data_d;
   logic [31:0]                    wr_addr_q, wr_addr_d;
   logic                           i_valid_q, i_valid_d;
   logic [IN_CHANNEL-1:0][7:0]     i_data_q, i_data_d;

   assign s_w_ready      = (state_q == S_LOAD_W);
   assign s_px_ready     = (state_q == S_STREAM) && !fifo_almost_full;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign weight_wr_en   = wr_en_q;
   assign weight_wr_data = wr_data_q;
   assign weight_wr_addr = wr_addr_q;
   assign i_valid        = i_valid_q;
   assign i_data         = i_data_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d   = state_q;
      waddr_d   = waddr_q;
      pix_d     = pix_q;
      lane_d    = lane_q;
      part_d    = part_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      wr_addr_d = wr_addr_q;
      i_valid_d = 1'b0;
      i_data_d  = i_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = skip_weights ? S_STREAM : S_LOAD_W;
         end
         S_LOAD_W: begin
            if (s_w_valid) begin
               wr_en_d   = 1'b1;
               wr_data_d = s_w_data;
               wr_addr_d = 32'(waddr_q);
               if (waddr_q == WADDR_LAST) begin
                  waddr_d = '0;
                  state_d = S_STREAM;
               end else begin
                  waddr_d = waddr_q + 1'b1;
               end
            end
         end
         S_STREAM: begin
            if (s_px_valid && s_px_ready) begin
               part_d[lane_q] = s_px_data;
               // The completed word includes the byte arriving this cycle.
               if (lane_q == LANE_LAST) begin
                  lane_d    = '0;
                  i_valid_d = 1'b1;
                  i_data_d  = part_d;
                  if (pix_q == PIX_LAST) begin
                     pix_d   = '0;
                     state_d = S_DONE;
                  end else begin
                     pix_d = pix_q + 1'b1;
                  end
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q   <= S_IDLE;
         waddr_q   <= '0;
         pix_q     <= '0;
         lane_q    <= '0;
         part_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         i_valid_q <= 1'b0;
         i_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         waddr_q   <= waddr_d;
         pix_q     <= pix_d;
         lane_q    <= lane_d;
         part_q    <= part_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         wr_addr_q <= wr_addr_d;
         i_valid_q <= i_valid_d;
         i_data_q  <= i_data_d;
      end
   end

endmodule
